// File: rtl/csr_pkg.sv
// ---------------------------------------------------------------------------
// csr_pkg
//   Shared definitions for the machine-mode CSR access path: fixed CSR
//   addresses (local machine CSRs and the read-only counters), the CSR
//   operation encoding, the access FSM state encoding, the writable mask
//   for mcountinhibit, and small helpers for address decode and the
//   read-modify-write operation.
//   No ports (package).
// ---------------------------------------------------------------------------
package csr_pkg;

  // Local machine CSRs held inside the arbiter
  localparam logic [11:0] ADDR_MTVEC         = 12'h305;
  localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] ADDR_MSCRATCH      = 12'h340;
  localparam logic [11:0] ADDR_MEPC          = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE        = 12'h342;

  // Read-only counters served by the neighbouring counter block
  localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
  localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
  localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
  localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;

  // Only CY (bit 0) and IR (bit 2) of mcountinhibit exist
  localparam logic [31:0] MCOUNTINHIBIT_MASK = 32'h0000_0005;

  // mtvec and mepc are word aligned, their two low bits always read as 0
  localparam logic [31:0] ALIGN4_MASK        = 32'hFFFF_FFFC;

  // CSR operation encoding as it arrives on the request ports
  typedef enum logic [1:0] {
    OP_ILL = 2'b00,
    OP_RW  = 2'b01,
    OP_RS  = 2'b10,
    OP_RC  = 2'b11
  } csr_op_e;

  // Access FSM: accept in IDLE, fetch old value in READ, commit/respond in WRITE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } csr_state_e;

  // True when the address names one of the read-only counters
  function automatic logic isCounterAddr(input logic [11:0] addr);
    return (addr == ADDR_CYCLE)  || (addr == ADDR_INSTRET) ||
           (addr == ADDR_CYCLEH) || (addr == ADDR_INSTRETH);
  endfunction

  // True when the operation has to modify the CSR; RS/RC with a zero
  // operand is a pure read and must stay legal on read-only counters
  function automatic logic needsWrite(input csr_op_e op, input logic [31:0] operand);
    return (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && (operand != 32'h0));
  endfunction

  // New CSR value for a read-modify-write operation
  function automatic logic [31:0] applyOp(input csr_op_e op,
                                          input logic [31:0] oldVal,
                                          input logic [31:0] operand);
    logic [31:0] result;
    case (op)
      OP_RW:   result = operand;
      OP_RS:   result = oldVal | operand;
      OP_RC:   result = oldVal & ~operand;
      default: result = oldVal;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
//   Two-requester round-robin arbiter. Requester 0 is the core pipeline,
//   requester 1 is the debug port. A grant is only ever given to a valid
//   requester, so a grant is itself the handshake and the last-grant flop
//   moves on every grant.
//   Ports:
//     i_clk     core clock
//     i_rst     asynchronous active-high reset
//     i_enable  arbitration allowed this cycle (consumer is idle)
//     i_req     [1:0] request valids, bit 0 = core, bit 1 = debug
//     o_gnt     [1:0] one-hot (or zero) grant
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_enable,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Remembers whether the debug port won the most recent handshake.
  // Resetting it to 1 makes the core the favoured requester after reset.
  logic r_lastDbg;

  // Grant selection: a lone requester always wins; on contention the
  // requester that did not win last time gets the slot.
  always_comb begin
    o_gnt = 2'b00;
    if (i_enable) begin
      if (i_req == 2'b11) begin
        o_gnt = r_lastDbg ? 2'b01 : 2'b10;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  // Pointer update happens only when a handshake takes place, so idle
  // cycles or cycles spent busy never disturb the fairness order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lastDbg <= 1'b1;
    end else if (o_gnt != 2'b00) begin
      r_lastDbg <= o_gnt[1];
    end
  end

endmodule

// File: rtl/csr_access_arbiter.sv
// ---------------------------------------------------------------------------
// csr_access_arbiter
//   Machine-mode CSR access path. Arbitrates read-modify-write CSR requests
//   from the core pipeline and the debug port, executes CSRRW/CSRRS/CSRRC on
//   a small local CSR file (mtvec, mcountinhibit, mscratch, mepc, mcause),
//   forwards counter reads to the cycle/instret counter block and drives the
//   counter-inhibit bits back to it. One request is serviced every three
//   cycles: accept (IDLE), fetch old value (READ), commit and respond (WRITE).
//   Ports:
//     i_clk, i_rst                      clock, async active-high reset
//     i_core_req_valid / o_core_req_ready  core request handshake
//     i_core_op, i_core_addr, i_core_wdata core request payload
//     o_core_rsp_valid, o_core_rsp_rdata, o_core_rsp_err  core response pulse
//     i_dbg_* / o_dbg_*                 same set for the debug requester
//     o_cnt_addr                        address into the counter read mux
//     i_cnt_rdata                       counter value for o_cnt_addr
//     o_cnt_inhibit                     [0] stop cycle, [1] stop instret
// ---------------------------------------------------------------------------
module csr_access_arbiter
  import csr_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,

  input  logic        i_core_req_valid,
  output logic        o_core_req_ready,
  input  logic [1:0]  i_core_op,
  input  logic [11:0] i_core_addr,
  input  logic [31:0] i_core_wdata,
  output logic        o_core_rsp_valid,
  output logic [31:0] o_core_rsp_rdata,
  output logic        o_core_rsp_err,

  input  logic        i_dbg_req_valid,
  output logic        o_dbg_req_ready,
  input  logic [1:0]  i_dbg_op,
  input  logic [11:0] i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_rsp_valid,
  output logic [31:0] o_dbg_rsp_rdata,
  output logic        o_dbg_rsp_err,

  output logic [11:0] o_cnt_addr,
  input  logic [31:0] i_cnt_rdata,
  output logic [1:0]  o_cnt_inhibit
);

  // FSM state and the request latched at the handshake
  csr_state_e  r_state;
  logic        r_srcDbg;
  csr_op_e     r_op;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;

  // Old value captured in READ and the commit decision carried into WRITE
  logic [31:0] r_oldVal;
  logic        r_commit;

  // Local machine CSR file
  logic [31:0] r_mtvec;
  logic [31:0] r_mcountinhibit;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;

  // Arbitration and decode wires
  logic [1:0]  w_gnt;
  logic        w_arbEnable;
  logic        w_handshake;
  csr_op_e     w_reqOp;
  logic [11:0] w_reqAddr;
  logic [31:0] w_reqWdata;
  logic        w_localHit;
  logic [31:0] w_localVal;
  logic        w_counterHit;
  logic        w_writeReq;
  logic        w_legal;
  logic [31:0] w_readVal;
  logic [31:0] w_newVal;

  // Arbitration is only open in IDLE; holding it shut while reset is
  // asserted keeps both ready outputs at 0 during reset.
  assign w_arbEnable = (r_state == ST_IDLE) && !i_rst;

  rr_arb2 u_arb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (w_arbEnable),
    .i_req    ({i_dbg_req_valid, i_core_req_valid}),
    .o_gnt    (w_gnt)
  );

  // The arbiter never grants an idle requester, so ready doubles as the
  // handshake for whichever port it is shown to.
  assign o_core_req_ready = w_gnt[0];
  assign o_dbg_req_ready  = w_gnt[1];
  assign w_handshake      = |w_gnt;

  // Payload of the granted port; the other port's inputs are never looked at.
  always_comb begin
    w_reqOp    = csr_op_e'(i_core_op);
    w_reqAddr  = i_core_addr;
    w_reqWdata = i_core_wdata;
    if (w_gnt[1]) begin
      w_reqOp    = csr_op_e'(i_dbg_op);
      w_reqAddr  = i_dbg_addr;
      w_reqWdata = i_dbg_wdata;
    end
  end

  // Counter block only sees a real address while the old value is being
  // fetched; at all other times its read mux is parked on address 0.
  assign o_cnt_addr = (r_state == ST_READ) ? r_addr : 12'h000;

  // Local CSR read mux. The stored mtvec/mepc/mcountinhibit values are
  // already masked on write, so the read side can return them directly.
  always_comb begin
    w_localHit = 1'b1;
    w_localVal = 32'h0;
    case (r_addr)
      ADDR_MTVEC:         w_localVal = r_mtvec;
      ADDR_MCOUNTINHIBIT: w_localVal = r_mcountinhibit;
      ADDR_MSCRATCH:      w_localVal = r_mscratch;
      ADDR_MEPC:          w_localVal = r_mepc;
      ADDR_MCAUSE:        w_localVal = r_mcause;
      default:            w_localHit = 1'b0;
    endcase
  end

  // Legality: the op must be real, the address mapped, and counters may
  // only be read (RS/RC with a zero operand counts as a read).
  assign w_counterHit = isCounterAddr(r_addr);
  assign w_writeReq   = needsWrite(r_op, r_wdata);
  assign w_legal      = (r_op != OP_ILL) &&
                        (w_localHit || (w_counterHit && !w_writeReq));

  // Old value seen by the requester; an illegal access reports 0.
  always_comb begin
    w_readVal = 32'h0;
    if (w_legal) begin
      w_readVal = w_localHit ? w_localVal : i_cnt_rdata;
    end
  end

  // New value is derived from the old value latched in READ.
  assign w_newVal = applyOp(r_op, r_oldVal, r_wdata);

  // Counter inhibit bits map CY and IR straight onto the counter block.
  assign o_cnt_inhibit = {r_mcountinhibit[2], r_mcountinhibit[0]};

  // Main access FSM with registered responses. The response registers are
  // loaded on the READ->WRITE edge so the pulse lines up with the WRITE
  // cycle, and are cleared again on the following edge. CSR commits happen
  // on the WRITE->IDLE edge, so an asynchronous reset arriving in READ or
  // WRITE drops the transaction without any visible side effect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state          <= ST_IDLE;
      r_srcDbg         <= 1'b0;
      r_op             <= OP_ILL;
      r_addr           <= 12'h000;
      r_wdata          <= 32'h0;
      r_oldVal         <= 32'h0;
      r_commit         <= 1'b0;
      r_mtvec          <= 32'h0;
      r_mcountinhibit  <= 32'h0;
      r_mscratch       <= 32'h0;
      r_mepc           <= 32'h0;
      r_mcause         <= 32'h0;
      o_core_rsp_valid <= 1'b0;
      o_core_rsp_rdata <= 32'h0;
      o_core_rsp_err   <= 1'b0;
      o_dbg_rsp_valid  <= 1'b0;
      o_dbg_rsp_rdata  <= 32'h0;
      o_dbg_rsp_err    <= 1'b0;
    end else begin
      o_core_rsp_valid <= 1'b0;
      o_core_rsp_rdata <= 32'h0;
      o_core_rsp_err   <= 1'b0;
      o_dbg_rsp_valid  <= 1'b0;
      o_dbg_rsp_rdata  <= 32'h0;
      o_dbg_rsp_err    <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_srcDbg <= w_gnt[1];
            r_op     <= w_reqOp;
            r_addr   <= w_reqAddr;
            r_wdata  <= w_reqWdata;
            r_state  <= ST_READ;
          end
        end

        ST_READ: begin
          r_oldVal <= w_readVal;
          // Only local CSRs can ever be committed: a counter write is illegal
          r_commit <= w_legal && w_writeReq && w_localHit;
          if (r_srcDbg) begin
            o_dbg_rsp_valid  <= 1'b1;
            o_dbg_rsp_rdata  <= w_readVal;
            o_dbg_rsp_err    <= !w_legal;
          end else begin
            o_core_rsp_valid <= 1'b1;
            o_core_rsp_rdata <= w_readVal;
            o_core_rsp_err   <= !w_legal;
          end
          r_state <= ST_WRITE;
        end

        ST_WRITE: begin
          if (r_commit) begin
            case (r_addr)
              ADDR_MTVEC:         r_mtvec         <= w_newVal & ALIGN4_MASK;
              ADDR_MCOUNTINHIBIT: r_mcountinhibit <= w_newVal & MCOUNTINHIBIT_MASK;
              ADDR_MSCRATCH:      r_mscratch      <= w_newVal;
              ADDR_MEPC:          r_mepc          <= w_newVal & ALIGN4_MASK;
              ADDR_MCAUSE:        r_mcause        <= w_newVal;
              default:            r_mscratch      <= r_mscratch;
            endcase
          end
          r_commit <= 1'b0;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_access_arbiter.sv
// ---------------------------------------------------------------------------
// tb_csr_access_arbiter
//   Directed bench for csr_access_arbiter. A tiny counter-block model answers
//   0x55 for cycle (0xC00) and 0x77 for instret (0xC02). Expected values are
//   hand-computed constants.
// ---------------------------------------------------------------------------
module tb_csr_access_arbiter;

  logic        clk;
  logic        rst;
  logic        coreReqValid;
  logic        coreReqReady;
  logic [1:0]  coreOp;
  logic [11:0] coreAddr;
  logic [31:0] coreWdata;
  logic        coreRspValid;
  logic [31:0] coreRspRdata;
  logic        coreRspErr;
  logic        dbgReqValid;
  logic        dbgReqReady;
  logic [1:0]  dbgOp;
  logic [11:0] dbgAddr;
  logic [31:0] dbgWdata;
  logic        dbgRspValid;
  logic [31:0] dbgRspRdata;
  logic        dbgRspErr;
  logic [11:0] cntAddr;
  logic [31:0] cntRdata;
  logic [1:0]  cntInhibit;

  int checks = 0;
  int errors = 0;

  // Values captured by applyStimulus for the last transaction
  logic        obsReady;
  logic        obsEarly;
  logic        obsOwnValid;
  logic        obsOtherValid;
  logic [31:0] obsRdata;
  logic        obsErr;
  logic [11:0] obsCntAddr;
  logic [1:0]  obsInhibit;

  csr_access_arbiter dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_core_req_valid (coreReqValid),
    .o_core_req_ready (coreReqReady),
    .i_core_op        (coreOp),
    .i_core_addr      (coreAddr),
    .i_core_wdata     (coreWdata),
    .o_core_rsp_valid (coreRspValid),
    .o_core_rsp_rdata (coreRspRdata),
    .o_core_rsp_err   (coreRspErr),
    .i_dbg_req_valid  (dbgReqValid),
    .o_dbg_req_ready  (dbgReqReady),
    .i_dbg_op         (dbgOp),
    .i_dbg_addr       (dbgAddr),
    .i_dbg_wdata      (dbgWdata),
    .o_dbg_rsp_valid  (dbgRspValid),
    .o_dbg_rsp_rdata  (dbgRspRdata),
    .o_dbg_rsp_err    (dbgRspErr),
    .o_cnt_addr       (cntAddr),
    .i_cnt_rdata      (cntRdata),
    .o_cnt_inhibit    (cntInhibit)
  );

  // Counter block stand-in with a combinational read mux
  assign cntRdata = (cntAddr == 12'hC00) ? 32'h0000_0055 :
                    (cntAddr == 12'hC02) ? 32'h0000_0077 : 32'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One complete transaction on one port: present at a negedge, handshake at
  // the next posedge, then sample READ, WRITE and the following IDLE cycle.
  task automatic applyStimulus(input bit useDbg, input logic [1:0] op,
                               input logic [11:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    if (useDbg) begin
      dbgReqValid = 1'b1; dbgOp = op; dbgAddr = addr; dbgWdata = wdata;
    end else begin
      coreReqValid = 1'b1; coreOp = op; coreAddr = addr; coreWdata = wdata;
    end
    #1;
    obsReady = useDbg ? dbgReqReady : coreReqReady;
    @(posedge clk); #1;
    // READ cycle: scramble the payload to prove it was latched
    coreReqValid = 1'b0; dbgReqValid = 1'b0;
    coreAddr = 12'h7FF; dbgAddr = 12'h7FF;
    coreWdata = ~wdata; dbgWdata = ~wdata;
    coreOp = 2'b00; dbgOp = 2'b00;
    obsEarly   = coreRspValid | dbgRspValid;
    obsCntAddr = cntAddr;
    @(posedge clk); #1;
    obsOwnValid   = useDbg ? dbgRspValid : coreRspValid;
    obsOtherValid = useDbg ? coreRspValid : dbgRspValid;
    obsRdata      = useDbg ? dbgRspRdata : coreRspRdata;
    obsErr        = useDbg ? dbgRspErr : coreRspErr;
    @(posedge clk); #1;
    obsInhibit = cntInhibit;
  endtask

  task automatic doTxn(input string tag, input bit useDbg, input logic [1:0] op,
                       input logic [11:0] addr, input logic [31:0] wdata,
                       input logic [31:0] expRdata, input logic expErr);
    applyStimulus(useDbg, op, addr, wdata);
    checkOutput({tag, "_ready"}, 32'(obsReady), 32'd1);
    checkOutput({tag, "_early"}, 32'(obsEarly), 32'd0);
    checkOutput({tag, "_valid"}, 32'(obsOwnValid), 32'd1);
    checkOutput({tag, "_other"}, 32'(obsOtherValid), 32'd0);
    checkOutput({tag, "_rdata"}, obsRdata, expRdata);
    checkOutput({tag, "_err"}, 32'(obsErr), 32'(expErr));
  endtask

  // Holds reset across two edges with a core request pending and checks
  // that every output stays at 0 meanwhile.
  task automatic resetDut(input string tag);
    @(negedge clk);
    rst = 1'b1;
    coreReqValid = 1'b1; coreOp = 2'b01; coreAddr = 12'h340; coreWdata = 32'h1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput({tag, "_ready"}, {30'd0, dbgReqReady, coreReqReady}, 32'd0);
    checkOutput({tag, "_rsp"}, {30'd0, dbgRspValid, coreRspValid}, 32'd0);
    checkOutput({tag, "_inhibit"}, 32'(cntInhibit), 32'd0);
    checkOutput({tag, "_cntaddr"}, 32'(cntAddr), 32'd0);
    @(negedge clk);
    coreReqValid = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    coreReqValid = 1'b0; coreOp = 2'b00; coreAddr = 12'h0; coreWdata = 32'h0;
    dbgReqValid  = 1'b0; dbgOp  = 2'b00; dbgAddr  = 12'h0; dbgWdata  = 32'h0;

    resetDut("rst0");

    // mscratch write then pure read
    doTxn("mscratch_rw", 1'b0, 2'b01, 12'h340, 32'hDEADBEEF, 32'h0, 1'b0);
    doTxn("mscratch_rd", 1'b0, 2'b10, 12'h340, 32'h0, 32'hDEADBEEF, 1'b0);

    // mtvec low bits read as 0
    doTxn("mtvec_rw", 1'b0, 2'b01, 12'h305, 32'h12345677, 32'h0, 1'b0);
    doTxn("mtvec_rd", 1'b0, 2'b10, 12'h305, 32'h0, 32'h12345674, 1'b0);

    // mepc clear-all after writing 0x103
    doTxn("mepc_rw", 1'b0, 2'b01, 12'h341, 32'h00000103, 32'h0, 1'b0);
    doTxn("mepc_rc", 1'b0, 2'b11, 12'h341, 32'hFFFFFFFF, 32'h100, 1'b0);
    doTxn("mepc_rd", 1'b0, 2'b10, 12'h341, 32'h0, 32'h0, 1'b0);

    // mcountinhibit: only CY and IR stick, inhibit visible after WRITE
    doTxn("minh_rw", 1'b0, 2'b01, 12'h320, 32'hFFFFFFFF, 32'h0, 1'b0);
    checkOutput("minh_inhibit", 32'(obsInhibit), 32'd3);
    doTxn("minh_rd", 1'b0, 2'b10, 12'h320, 32'h0, 32'h5, 1'b0);
    doTxn("minh_rc", 1'b0, 2'b11, 12'h320, 32'h1, 32'h5, 1'b0);
    checkOutput("minh_inhibit2", 32'(obsInhibit), 32'd2);

    // Counter read through the counter block and illegal accesses
    doTxn("cycle_rd", 1'b0, 2'b10, 12'hC00, 32'h0, 32'h55, 1'b0);
    checkOutput("cycle_cntaddr", 32'(obsCntAddr), 32'h0C00);
    doTxn("cycle_rw", 1'b0, 2'b01, 12'hC00, 32'h1, 32'h0, 1'b1);
    doTxn("cycle_rs", 1'b0, 2'b10, 12'hC00, 32'h4, 32'h0, 1'b1);
    doTxn("instret_rc0", 1'b1, 2'b11, 12'hC02, 32'h0, 32'h77, 1'b0);
    doTxn("unmapped", 1'b0, 2'b10, 12'h7FF, 32'h0, 32'h0, 1'b1);
    doTxn("op_ill", 1'b0, 2'b00, 12'h340, 32'h12345678, 32'h0, 1'b1);
    doTxn("op_ill_nochg", 1'b0, 2'b10, 12'h340, 32'h0, 32'hDEADBEEF, 1'b0);

    // Debug port path into mcause, read back from the core side
    doTxn("dbg_mcause_rw", 1'b1, 2'b01, 12'h342, 32'h80000007, 32'h0, 1'b0);
    doTxn("dbg_mcause_rs", 1'b1, 2'b10, 12'h342, 32'h00000010, 32'h80000007, 1'b0);
    doTxn("core_mcause_rd", 1'b0, 2'b10, 12'h342, 32'h0, 32'h80000017, 1'b0);

    // Reset clears the local CSRs and the inhibit bits
    resetDut("rst1");
    doTxn("post_rst_mscratch", 1'b0, 2'b10, 12'h340, 32'h0, 32'h0, 1'b0);

    // Round robin with both ports requesting every cycle from reset
    resetDut("rst2");
    coreReqValid = 1'b1; coreOp = 2'b10; coreAddr = 12'hC00; coreWdata = 32'h0;
    dbgReqValid  = 1'b1; dbgOp  = 2'b10; dbgAddr  = 12'hC02; dbgWdata  = 32'h0;
    for (int i = 0; i < 12; i++) begin
      int phase;
      bit dbgTurn;
      logic [1:0] expReady;
      logic [1:0] expRsp;
      phase   = i % 3;
      dbgTurn = ((i / 3) % 2) == 1;
      expReady = 2'b00;
      expRsp   = 2'b00;
      if (phase == 0) expReady = dbgTurn ? 2'b10 : 2'b01;
      if (phase == 2) expRsp   = dbgTurn ? 2'b10 : 2'b01;
      #1;
      checkOutput($sformatf("rr_ready_%0d", i), {30'd0, dbgReqReady, coreReqReady},
                  {30'd0, expReady});
      checkOutput($sformatf("rr_rsp_%0d", i), {30'd0, dbgRspValid, coreRspValid},
                  {30'd0, expRsp});
      if (phase == 2) begin
        checkOutput($sformatf("rr_rdata_%0d", i),
                    dbgTurn ? dbgRspRdata : coreRspRdata,
                    dbgTurn ? 32'h77 : 32'h55);
      end
      @(negedge clk);
    end
    coreReqValid = 1'b0;
    dbgReqValid  = 1'b0;

    // Reset during READ of a core write drops it completely
    resetDut("rst3");
    coreReqValid = 1'b1; coreOp = 2'b01; coreAddr = 12'h340; coreWdata = 32'hAAAA0000;
    @(posedge clk); #1;
    coreReqValid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_rsp0", {30'd0, dbgRspValid, coreRspValid}, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("midrst_rsp%0d", k + 1), {30'd0, dbgRspValid, coreRspValid},
                  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    doTxn("midrst_rd", 1'b0, 2'b10, 12'h340, 32'h0, 32'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
